// File: rtl/call_return_ctrl.sv
// CALL/RET sequencer driving push/pop strobes on the hardware return stack and PC loads.
// Optional shadow depth counter and `depth` port enabled by defining CRC_SHADOW_DEPTH_EN.
module call_return_ctrl #(
    parameter int unsigned MAX_DEPTH = 128
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic [15:0] pc,
    input  logic [15:0] target_addr,
    input  logic        stack_full,
    input  logic        stack_empty,
    input  logic [15:0] stack_dout,
    input  logic        fault_clr,
    output logic        stack_push,
    output logic        stack_pop,
    output logic [15:0] stack_din,
    output logic        pc_load,
    output logic [15:0] pc_next,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code
`ifdef CRC_SHADOW_DEPTH_EN
    ,
    output logic [7:0]  depth
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALL_PUSH,
        ST_CALL_JUMP,
        ST_RET_POP,
        ST_RET_CAPT,
        ST_RET_JUMP,
        ST_FAULT
    } state_e;

    state_e      state_q, state_d;
    logic        stack_push_q, stack_push_d;
    logic        stack_pop_q, stack_pop_d;
    logic [15:0] stack_din_q, stack_din_d;
    logic        pc_load_q, pc_load_d;
    logic [15:0] pc_next_q, pc_next_d;
    logic [15:0] target_q, target_d;
    logic        busy_q, busy_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic        call_ovf, ret_udf;

`ifdef CRC_SHADOW_DEPTH_EN
    logic [7:0] depth_q, depth_d;

    assign call_ovf = stack_full  || (depth_q == 8'(MAX_DEPTH));
    assign ret_udf  = stack_empty || (depth_q == 8'd0);

    always_comb begin
        depth_d = depth_q;
        if (state_q == ST_CALL_PUSH)
            depth_d = depth_q + 8'd1;
        else if (state_q == ST_RET_POP)
            depth_d = depth_q - 8'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) depth_q <= '0;
        else          depth_q <= depth_d;
    end

    assign depth = depth_q;
`else
    assign call_ovf = stack_full;
    assign ret_udf  = stack_empty;
`endif

    // Outputs are decoded from the next state so every strobe comes straight off a flop.
    always_comb begin
        state_d      = state_q;
        stack_push_d = 1'b0;
        stack_pop_d  = 1'b0;
        pc_load_d    = 1'b0;
        stack_din_d  = stack_din_q;
        pc_next_d    = pc_next_q;
        target_d     = target_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;

        case (state_q)
            ST_IDLE: begin
                if (call_req) begin
                    if (call_ovf) begin
                        state_d      = ST_FAULT;
                        fault_d      = 1'b1;
                        fault_code_d = 2'b01;
                    end else begin
                        state_d      = ST_CALL_PUSH;
                        stack_push_d = 1'b1;
                        stack_din_d  = pc + 16'd1;
                        target_d     = target_addr;
                    end
                end else if (ret_req) begin
                    if (ret_udf) begin
                        state_d      = ST_FAULT;
                        fault_d      = 1'b1;
                        fault_code_d = 2'b10;
                    end else begin
                        state_d     = ST_RET_POP;
                        stack_pop_d = 1'b1;
                    end
                end
            end
            ST_CALL_PUSH: begin
                state_d   = ST_CALL_JUMP;
                pc_load_d = 1'b1;
                pc_next_d = target_q;
            end
            ST_CALL_JUMP: state_d = ST_IDLE;
            ST_RET_POP:   state_d = ST_RET_CAPT;
            // Pop data is only valid during this cycle.
            ST_RET_CAPT: begin
                state_d   = ST_RET_JUMP;
                pc_load_d = 1'b1;
                pc_next_d = stack_dout;
            end
            ST_RET_JUMP:  state_d = ST_IDLE;
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d      = ST_IDLE;
                    fault_d      = 1'b0;
                    fault_code_d = 2'b00;
                end
            end
            default:      state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            stack_push_q <= 1'b0;
            stack_pop_q  <= 1'b0;
            stack_din_q  <= '0;
            pc_load_q    <= 1'b0;
            pc_next_q    <= '0;
            target_q     <= '0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= '0;
        end else begin
            state_q      <= state_d;
            stack_push_q <= stack_push_d;
            stack_pop_q  <= stack_pop_d;
            stack_din_q  <= stack_din_d;
            pc_load_q    <= pc_load_d;
            pc_next_q    <= pc_next_d;
            target_q     <= target_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign stack_push = stack_push_q;
    assign stack_pop  = stack_pop_q;
    assign stack_din  = stack_din_q;
    assign pc_load    = pc_load_q;
    assign pc_next    = pc_next_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Scoreboard bench for call_return_ctrl: stimulus queues expected strobes, a negedge monitor checks them.
module tb_call_return_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        call_req = 1'b0, ret_req = 1'b0, fault_clr = 1'b0;
    logic [15:0] pc = '0, target_addr = '0;
    logic        stack_full, stack_empty;
    logic [15:0] stack_dout;
    logic        stack_push, stack_pop, pc_load, busy, fault;
    logic [15:0] stack_din, pc_next;
    logic [1:0]  fault_code;
`ifdef CRC_SHADOW_DEPTH_EN
    logic [7:0]  depth;
`endif

    call_return_ctrl #(.MAX_DEPTH(128)) dut (
        .clock(clock), .reset_n(reset_n), .call_req(call_req), .ret_req(ret_req),
        .pc(pc), .target_addr(target_addr), .stack_full(stack_full),
        .stack_empty(stack_empty), .stack_dout(stack_dout), .fault_clr(fault_clr),
        .stack_push(stack_push), .stack_pop(stack_pop), .stack_din(stack_din),
        .pc_load(pc_load), .pc_next(pc_next), .busy(busy), .fault(fault),
        .fault_code(fault_code)
`ifdef CRC_SHADOW_DEPTH_EN
        , .depth(depth)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // Return stack model: 128 deep, pop data valid for exactly one cycle.
    logic [15:0] mem [128];
    int          sp = 0;
    logic [15:0] dout_r = 16'hDEAD;
    assign stack_full  = (sp == 128);
    assign stack_empty = (sp == 0);
    assign stack_dout  = dout_r;
    always @(posedge clock) begin
        dout_r = 16'hDEAD;
        if (stack_push && sp < 128) begin
            mem[sp] = stack_din;
            sp++;
        end else if (stack_pop && sp > 0) begin
            sp--;
            dout_r = mem[sp];
        end
    end

    typedef enum int {EV_PUSH, EV_POP, EV_LOAD, EV_FAULT} ev_e;
    typedef struct {
        ev_e         kind;
        logic [15:0] data;
        int          at;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input ev_e k, input logic [15:0] d, input int at);
        exp_t e;
        e.kind = k; e.data = d; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_e k, input logic [15:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual=%s required=none (cycle %0d)", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_data", {16'h0, d}, {16'h0, e.data});
            chk("event_cycle", cyc, e.at);
        end
    endtask

    logic fault_prev = 1'b0;
    always @(negedge clock) begin
        if (reset_n) begin
            if (stack_push && stack_pop) chk("push_pop_overlap", 1, 0);
            if (stack_push) observe(EV_PUSH, stack_din);
            if (stack_pop)  observe(EV_POP, 16'h0);
            if (pc_load)    observe(EV_LOAD, pc_next);
            if (fault && !fault_prev) observe(EV_FAULT, {14'h0, fault_code});
            fault_prev = fault;
        end else begin
            fault_prev = 1'b0;
        end
    end

    int base;

    task automatic issue(input logic c, input logic r, input logic [15:0] p, input logic [15:0] t);
        @(negedge clock);
        call_req = c; ret_req = r; pc = p; target_addr = t;
        base = cyc;
    endtask

    task automatic finish_req(input int exp_busy);
        int nb = 0;
        @(negedge clock);
        call_req = 1'b0; ret_req = 1'b0;
        while (busy && nb < 20) begin
            nb++;
            @(negedge clock);
        end
        chk("busy_cycles", nb, exp_busy);
    endtask

    task automatic do_call(input logic [15:0] p, input logic [15:0] t);
        issue(1'b1, 1'b0, p, t);
        expect_ev(EV_PUSH, p + 16'd1, base + 1);
        expect_ev(EV_LOAD, t, base + 2);
        finish_req(2);
    endtask

    task automatic do_ret(input logic [15:0] v);
        issue(1'b0, 1'b1, 16'h0, 16'h0);
        expect_ev(EV_POP, 16'h0, base + 1);
        expect_ev(EV_LOAD, v, base + 3);
        finish_req(3);
    endtask

    task automatic do_fault(input logic c, input logic r, input logic [1:0] code);
        issue(c, r, 16'h0100, 16'h0400);
        expect_ev(EV_FAULT, {14'h0, code}, base + 1);
        @(negedge clock);
        call_req = 1'b0; ret_req = 1'b0;
        chk("fault_set", fault, 1);
        chk("fault_code", fault_code, code);
        chk("fault_busy", busy, 1);
        repeat (2) @(negedge clock);
        chk("fault_sticky", fault, 1);
        fault_clr = 1'b1;
        @(negedge clock);
        fault_clr = 1'b0;
        chk("fault_cleared", fault, 0);
        chk("fault_code_cleared", fault_code, 0);
        chk("idle_after_clear", busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_outs"}, {stack_push, stack_pop, pc_load, busy, fault, fault_code}, 7'h0);
        chk({tag, "_din"}, stack_din, 0);
        chk({tag, "_pc_next"}, pc_next, 0);
`ifdef CRC_SHADOW_DEPTH_EN
        chk({tag, "_depth"}, depth, 0);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        @(negedge clock);

        do_call(16'h0010, 16'h0200);
        do_ret(16'h0011);

        do_fault(1'b0, 1'b1, 2'b10);
        do_call(16'h1234, 16'h0ABC);

        for (int i = 0; i < 127; i++)
            do_call(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        chk("stack_full_model", stack_full, 1);
`ifdef CRC_SHADOW_DEPTH_EN
        chk("depth_at_max", depth, 8'd128);
`endif
        do_fault(1'b1, 1'b0, 2'b01);

        do_ret(16'h107F);

        // Simultaneous request: CALL wins, pc wraps, no pop
        issue(1'b1, 1'b1, 16'hFFFF, 16'h0300);
        expect_ev(EV_PUSH, 16'h0000, base + 1);
        expect_ev(EV_LOAD, 16'h0300, base + 2);
        finish_req(2);
        do_ret(16'h0000);

        // Reset during CALL_PUSH
        issue(1'b1, 1'b0, 16'h0040, 16'h0500);
        @(posedge clock);
        #2;
        chk("push_before_reset", stack_push, 1);
        call_req = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("push_drops_on_reset", stack_push, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check_idle_outputs("post_reset");
        repeat (3) @(negedge clock);
        chk("still_idle_after_reset", {busy, pc_load, stack_push}, 0);

        do_call(16'h0005, 16'h0777);

        repeat (4) @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
